para_cap_arb: RTL and testbench
===============================

# para_cap_arb

Capture controller and write-port arbiter placed in front of `para_regs` inside `para_top`. It buffers the `sm_data`/`sm_vld` sample stream in a small FIFO. Each captured 16-bit sample becomes two byte writes into the parameter register space, starting at a programmable base address. Host fx-bus writes share the same write port and always win arbitration; capture writes fill the idle cycles.

## Interface
- `FIFO_AW`, 3, log2 of sample FIFO depth (depth = 8 samples)
- `clk_sys`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `fx_wr`  in  1  host write strobe, one cycle per byte
- `fx_waddr`  in  22  host write address
- `fx_data`  in  8  host write data
- `sm_data`  in  16  sample data, valid when `sm_vld`=1
- `sm_vld`  in  1  sample strobe, may be asserted every cycle
- `cap_start`  in  1  one-cycle pulse; arms a capture
- `cap_abort`  in  1  one-cycle pulse; cancels a capture
- `cap_base`  in  22  first byte address of the capture buffer
- `cap_len`  in  16  number of samples to capture
- `reg_wr`  out  1  merged write strobe to `para_regs`
- `reg_waddr`  out  22  merged write address
- `reg_data`  out  8  merged write data
- `cap_busy`  out  1  state is RUN or DRAIN
- `cap_done`  out  1  sticky; set on completion, cleared by `cap_start` or `rst`
- `cap_ovf`  out  1  sticky; sample dropped because the FIFO was full, cleared by `cap_start` or `rst`
- `cap_cnt`  out  16  number of samples fully written (both bytes)

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: accepting samples.
  - DRAIN: all `cap_len` samples accepted, FIFO still emptying.
  - DONE: all samples written.
- State transitions:
  - IDLE or DONE, with `cap_start`: latch `cap_base` and `cap_len`; clear `cap_cnt`, accepted-count, `cap_done`, `cap_ovf`; flush FIFO; go to RUN.
  - With a latched length of 0, go straight to DONE and set `cap_done`.
  - RUN: a sample with `sm_vld`=1 is pushed if the FIFO is not full and accepted-count < length. When accepted-count reaches length, go to DRAIN.
  - FIFO full with `sm_vld`=1 in RUN: the sample is dropped, `cap_ovf` is set, and accepted-count is not incremented.
  - DRAIN: when the FIFO is empty and the byte sequencer is idle, go to DONE and set `cap_done`.
  - `cap_start` while in RUN or DRAIN: ignored.
  - `cap_abort` in any state: go to IDLE, flush FIFO, drop any half-written sample, leave `cap_cnt` unchanged, leave `cap_done` clear.
  - `cap_abort` and `cap_start` in the same cycle: abort wins.
- Byte sequencer:
  - Pops the FIFO head and emits the low byte to address `base + 2*cap_cnt`, then the high byte to `+1`.
  - `cap_cnt` increments when the high byte is issued.
  - Addresses are computed modulo 2^22, so they wrap silently.
- Arbitration, each cycle:
  - `fx_wr`=1: the host byte is issued and the sequencer holds its pending byte unchanged.
  - Otherwise, the pending capture byte is issued, if one exists.
  - The host is never stalled or dropped.
- Simultaneous push and pop on a full FIFO: both happen and occupancy is unchanged.
- Samples arriving in IDLE, DRAIN or DONE are ignored and do not set `cap_ovf`.

## Timing
- All outputs are registered.
- Reset values: every output is 0. State is IDLE and the FIFO is empty.
- Host path latency is exactly 1 cycle: `fx_*` at cycle N appears on `reg_*` at N+1.
- Capture path, earliest case: `sm_vld` at N is pushed at N+1. The low byte appears on `reg_wr` at N+2 and the high byte at N+3, with no host traffic.
- Sustained capture throughput is 1 sample per 2 free cycles. With `sm_vld` every cycle, the FIFO fills and `cap_ovf` is expected behaviour.
- State and status timing:
  - `cap_busy` rises 1 cycle after `cap_start`.
  - `cap_done` rises in the cycle after the last high byte appears on `reg_wr`.
  - `cap_busy` falls in that same cycle.
- When `reg_wr`=0, `reg_waddr` and `reg_data` hold their last values.

## Test plan
- Host only: write 0xA5 to 0x000010 at cycle 5 with capture idle → `reg_wr`=1, `reg_waddr`=0x000010, `reg_data`=0xA5 at cycle 6, and no other writes.
- Basic capture: `cap_base`=0x000100, `cap_len`=3, samples 0x1234, 0xABCD, 0x00FF spaced 4 cycles apart → exactly these six writes in this order, then `cap_done`=1, `cap_cnt`=3, `cap_ovf`=0:
  - 0x100=0x34, 0x101=0x12
  - 0x102=0xCD, 0x103=0xAB
  - 0x104=0xFF, 0x105=0x00
- Contention: `cap_len`=4 with `fx_wr` asserted on alternate cycles → all host writes appear with 1-cycle latency, and all 8 capture bytes appear in order with correct addresses.
- Overflow: `cap_len`=20 with `sm_vld` held high for 20 cycles and the host writing every cycle → `cap_ovf`=1 and capture stays in RUN. After the host goes quiet:
  - Exactly the accepted samples are written.
  - `cap_cnt` equals the accepted count.
  - Capture stays in RUN until further samples arrive.
- Boundaries:
  - `cap_len`=0 → `cap_done`=1 two cycles after start, with no writes.
  - `cap_base`=0x3FFFFE, `cap_len`=2 → writes go to 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
- Abort between the low and high byte → no high byte is written, state returns to IDLE, `cap_busy`=0 and `cap_done`=0. A following `cap_start` begins cleanly at `cap_base`.

Source files
------------

// File: rtl/para_cap_arb_if.sv
// Shared write-port and sample-stream bundle for para_cap_arb.
// Master drives host bytes and samples; slave returns the merged write.
interface para_cap_arb_if;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic [15:0] sm_data;
  logic        sm_vld;
  logic        reg_wr;
  logic [21:0] reg_waddr;
  logic [7:0]  reg_data;

  modport master (
    output fx_wr, fx_waddr, fx_data,
    output sm_data, sm_vld,
    input  reg_wr, reg_waddr, reg_data
  );

  modport slave (
    input  fx_wr, fx_waddr, fx_data,
    input  sm_data, sm_vld,
    output reg_wr, reg_waddr, reg_data
  );
endinterface

// File: rtl/para_cap_arb.sv
// Sample capture FIFO plus byte sequencer sharing the para_regs
// write port with the host; host writes always take priority.
module para_cap_arb #(
  parameter int FIFO_AW = 3
) (
  input  logic          clk_sys,
  input  logic          rst,
  para_cap_arb_if.slave bus,
  input  logic          cap_start,
  input  logic          cap_abort,
  input  logic [21:0]   cap_base,
  input  logic [15:0]   cap_len,
  output logic          cap_busy,
  output logic          cap_done,
  output logic          cap_ovf,
  output logic [15:0]   cap_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [21:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] fifo_mem_q [DEPTH];
  logic        hi_pend_q, hi_pend_d;
  logic [7:0]  hi_byte_q, hi_byte_d;

  logic        reg_wr_q, reg_wr_d;
  logic [21:0] reg_waddr_q, reg_waddr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic [FIFO_AW:0] fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] head;
  logic [21:0] lo_addr;
  logic        active;
  logic        start_ok;
  logic        push;
  logic        drop;
  logic        pop;
  logic        issue_hi;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[FIFO_AW];
  assign head       = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign lo_addr    = base_q + {5'd0, cnt_q, 1'b0};
  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign start_ok   = cap_start && !cap_abort &&
                      ((state_q == IDLE) || (state_q == DONE));

  // A full FIFO still takes a sample when the head leaves this cycle
  always_comb begin
    pop      = 1'b0;
    issue_hi = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    if (active && !cap_abort && !bus.fx_wr) begin
      if (hi_pend_q) begin
        issue_hi = 1'b1;
      end else if (!fifo_empty) begin
        pop = 1'b1;
      end
    end
    if ((state_q == RUN) && !cap_abort &&
        bus.sm_vld && (acc_q < len_q)) begin
      if (!fifo_full || pop) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (len_q == '0) begin
          state_d = DONE;
        end else if (push && (acc_q + 16'd1 == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !hi_pend_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (cap_abort) state_d = IDLE;
  end

  always_comb begin
    base_d      = base_q;
    len_d       = len_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    hi_pend_d   = hi_pend_q;
    hi_byte_d   = hi_byte_q;
    reg_wr_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_data_d  = reg_data_q;
    done_d      = done_q;
    ovf_d       = ovf_q;

    if (bus.fx_wr) begin
      reg_wr_d    = 1'b1;
      reg_waddr_d = bus.fx_waddr;
      reg_data_d  = bus.fx_data;
    end else if (pop) begin
      reg_wr_d    = 1'b1;
      reg_waddr_d = lo_addr;
      reg_data_d  = head[7:0];
    end else if (issue_hi) begin
      reg_wr_d    = 1'b1;
      reg_waddr_d = lo_addr + 22'd1;
      reg_data_d  = hi_byte_q;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      acc_d    = acc_q + 16'd1;
    end
    if (drop) ovf_d = 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      hi_pend_d = 1'b1;
      hi_byte_d = head[15:8];
    end
    if (issue_hi) begin
      hi_pend_d = 1'b0;
      cnt_d     = cnt_q + 16'd1;
    end

    if (start_ok) begin
      base_d    = cap_base;
      len_d     = cap_len;
      acc_d     = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
      rd_ptr_d  = wr_ptr_q;
      hi_pend_d = 1'b0;
    end

    if (cap_abort) begin
      rd_ptr_d  = wr_ptr_q;
      hi_pend_d = 1'b0;
      done_d    = 1'b0;
    end

    if ((state_d == DONE) && (state_q != DONE)) done_d = 1'b1;
    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hi_pend_q   <= 1'b0;
      hi_byte_q   <= '0;
      reg_wr_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hi_pend_q   <= hi_pend_d;
      hi_byte_q   <= hi_byte_d;
      reg_wr_q    <= reg_wr_d;
      reg_waddr_q <= reg_waddr_d;
      reg_data_q  <= reg_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.sm_data;
  end

  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_data  = reg_data_q;
  assign cap_busy      = busy_q;
  assign cap_done      = done_q;
  assign cap_ovf       = ovf_q;
  assign cap_cnt       = cnt_q;
endmodule

// File: tb/tb_para_cap_arb.sv
// Bench for para_cap_arb: host table, directed capture sequences,
// and random traffic against a queue-based reference model.
module tb_para_cap_arb;
  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        cap_start = 1'b0;
  logic        cap_abort = 1'b0;
  logic [21:0] cap_base = '0;
  logic [15:0] cap_len = '0;
  logic        cap_busy, cap_done, cap_ovf;
  logic [15:0] cap_cnt;

  para_cap_arb_if bus ();

  para_cap_arb #(.FIFO_AW(3)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .bus       (bus),
    .cap_start (cap_start),
    .cap_abort (cap_abort),
    .cap_base  (cap_base),
    .cap_len   (cap_len),
    .cap_busy  (cap_busy),
    .cap_done  (cap_done),
    .cap_ovf   (cap_ovf),
    .cap_cnt   (cap_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [21:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wlog[$];

  typedef struct {
    logic        fx_wr;
    logic [21:0] a;
    logic [7:0]  d;
    logic        e_wr;
    logic [21:0] e_a;
    logic [7:0]  e_d;
  } vec_t;
  vec_t tbl[6];

  // reference model: phase 0 idle, 1 run, 2 drain, 3 done
  int          m_phase;
  logic [15:0] m_q[$];
  bit          m_half;
  logic [7:0]  m_hb;
  logic [21:0] m_base;
  logic [15:0] m_len, m_acc, m_cnt;
  bit          m_done, m_ovf;
  bit          e_wr;
  logic [21:0] e_addr;
  logic [7:0]  e_data;
  logic [15:0] exp_s[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_half = 0;
    m_hb = '0;
    m_base = '0;
    m_len = '0;
    m_acc = '0;
    m_cnt = '0;
    m_done = 0;
    m_ovf = 0;
    e_wr = 0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic step();
    bit drained;
    logic [15:0] s;
    drained = (m_q.size() == 0) && !m_half;
    e_wr = 0;
    if (bus.fx_wr) begin
      e_wr = 1;
      e_addr = bus.fx_waddr;
      e_data = bus.fx_data;
    end else if (!cap_abort && (m_phase == 1 || m_phase == 2)) begin
      if (m_half) begin
        e_wr = 1;
        e_addr = m_base + 22'(2 * m_cnt) + 22'd1;
        e_data = m_hb;
        m_half = 0;
        m_cnt++;
      end else if (m_q.size() > 0) begin
        s = m_q.pop_front();
        e_wr = 1;
        e_addr = m_base + 22'(2 * m_cnt);
        e_data = s[7:0];
        m_hb = s[15:8];
        m_half = 1;
      end
    end
    if (!cap_abort && m_phase == 1 && bus.sm_vld && m_acc < m_len) begin
      if (m_q.size() < 8) begin
        m_q.push_back(bus.sm_data);
        m_acc++;
      end else begin
        m_ovf = 1;
      end
    end
    if (cap_abort) begin
      m_phase = 0;
      m_q.delete();
      m_half = 0;
      m_done = 0;
    end else begin
      case (m_phase)
        0, 3: if (cap_start) begin
          m_base = cap_base;
          m_len = cap_len;
          m_acc = 0;
          m_cnt = 0;
          m_done = 0;
          m_ovf = 0;
          m_q.delete();
          m_half = 0;
          m_phase = 1;
        end
        1: if (m_len == 0) begin
          m_phase = 3;
          m_done = 1;
        end else if (m_acc == m_len) begin
          m_phase = 2;
        end
        2: if (drained) begin
          m_phase = 3;
          m_done = 1;
        end
        default: ;
      endcase
    end
    @(posedge clk_sys);
    #1;
    if (bus.reg_wr) wlog.push_back('{a: bus.reg_waddr, d: bus.reg_data});
    chk("m_reg_wr", 32'(bus.reg_wr), 32'(e_wr));
    chk("m_reg_waddr", 32'(bus.reg_waddr), 32'(e_addr));
    chk("m_reg_data", 32'(bus.reg_data), 32'(e_data));
    chk("m_busy", 32'(cap_busy), 32'(m_phase == 1 || m_phase == 2));
    chk("m_done", 32'(cap_done), 32'(m_done));
    chk("m_ovf", 32'(cap_ovf), 32'(m_ovf));
    chk("m_cnt", 32'(cap_cnt), 32'(m_cnt));
  endtask

  task automatic start_cap(logic [21:0] b, logic [15:0] l);
    cap_base = b;
    cap_len = l;
    cap_start = 1;
    step();
    cap_start = 0;
    chk("busy_rise", 32'(cap_busy), 32'(l != 0 || 1'b1));
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && !cap_done; i++) step();
    chk("done_wait", 32'(cap_done), 32'd1);
  endtask

  task automatic check_cap(string nm, logic [21:0] base, bit filt);
    wr_t c[$];
    logic [21:0] ea;
    foreach (wlog[i]) if (!filt || !wlog[i].a[21]) c.push_back(wlog[i]);
    chk({nm, "_nbytes"}, c.size(), 2 * exp_s.size());
    for (int k = 0; k < exp_s.size() && 2 * k + 1 < c.size(); k++) begin
      ea = base + 22'(2 * k);
      chk({nm, "_lo_addr"}, 32'(c[2*k].a), 32'(ea));
      chk({nm, "_lo_data"}, 32'(c[2*k].d), 32'(exp_s[k][7:0]));
      ea = ea + 22'd1;
      chk({nm, "_hi_addr"}, 32'(c[2*k+1].a), 32'(ea));
      chk({nm, "_hi_data"}, 32'(c[2*k+1].d), 32'(exp_s[k][15:8]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nh;
    bus.fx_wr = 0;
    bus.fx_waddr = '0;
    bus.fx_data = '0;
    bus.sm_data = '0;
    bus.sm_vld = 0;
    model_reset();

    tbl[0] = '{1'b1, 22'h000010, 8'hA5, 1'b1, 22'h000010, 8'hA5};
    tbl[1] = '{1'b0, 22'h000003, 8'h77, 1'b0, 22'h000010, 8'hA5};
    tbl[2] = '{1'b1, 22'h3FFFFF, 8'h5A, 1'b1, 22'h3FFFFF, 8'h5A};
    tbl[3] = '{1'b1, 22'h000000, 8'h00, 1'b1, 22'h000000, 8'h00};
    tbl[4] = '{1'b1, 22'h12345A, 8'hC3, 1'b1, 22'h12345A, 8'hC3};
    tbl[5] = '{1'b0, 22'h000000, 8'hFF, 1'b0, 22'h12345A, 8'hC3};

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_reg_wr", 32'(bus.reg_wr), 0);
    chk("rst_reg_waddr", 32'(bus.reg_waddr), 0);
    chk("rst_reg_data", 32'(bus.reg_data), 0);
    chk("rst_busy", 32'(cap_busy), 0);
    chk("rst_done", 32'(cap_done), 0);
    chk("rst_ovf", 32'(cap_ovf), 0);
    chk("rst_cnt", 32'(cap_cnt), 0);
    rst = 0;
    repeat (4) step();

    // host-only table
    wlog.delete();
    foreach (tbl[i]) begin
      bus.fx_wr = tbl[i].fx_wr;
      bus.fx_waddr = tbl[i].a;
      bus.fx_data = tbl[i].d;
      step();
      chk("tbl_wr", 32'(bus.reg_wr), 32'(tbl[i].e_wr));
      chk("tbl_addr", 32'(bus.reg_waddr), 32'(tbl[i].e_a));
      chk("tbl_data", 32'(bus.reg_data), 32'(tbl[i].e_d));
    end
    bus.fx_wr = 0;
    step();
    chk("tbl_nwrites", wlog.size(), 4);

    // basic capture
    wlog.delete();
    exp_s = '{16'h1234, 16'hABCD, 16'h00FF};
    start_cap(22'h000100, 16'd3);
    foreach (exp_s[k]) begin
      bus.sm_vld = 1;
      bus.sm_data = exp_s[k];
      step();
      bus.sm_vld = 0;
      repeat (3) step();
    end
    wait_done(20);
    chk("basic_cnt", 32'(cap_cnt), 3);
    chk("basic_ovf", 32'(cap_ovf), 0);
    chk("basic_busy", 32'(cap_busy), 0);
    check_cap("basic", 22'h000100, 0);

    // zero length
    wlog.delete();
    start_cap(22'h000200, 16'd0);
    chk("len0_done_early", 32'(cap_done), 0);
    step();
    chk("len0_done", 32'(cap_done), 1);
    chk("len0_busy", 32'(cap_busy), 0);
    repeat (2) step();
    chk("len0_nwrites", wlog.size(), 0);

    // address wrap
    wlog.delete();
    exp_s = '{16'hBEEF, 16'hC0DE};
    start_cap(22'h3FFFFE, 16'd2);
    foreach (exp_s[k]) begin
      bus.sm_vld = 1;
      bus.sm_data = exp_s[k];
      step();
    end
    bus.sm_vld = 0;
    wait_done(20);
    check_cap("wrap", 22'h3FFFFE, 0);

    // abort between low and high byte
    wlog.delete();
    start_cap(22'h000200, 16'd4);
    bus.sm_vld = 1;
    bus.sm_data = 16'h5566;
    step();
    bus.sm_vld = 0;
    step();
    chk("abort_lo_wr", 32'(bus.reg_wr), 1);
    chk("abort_lo_addr", 32'(bus.reg_waddr), 32'h200);
    cap_abort = 1;
    step();
    cap_abort = 0;
    chk("abort_no_hi", 32'(bus.reg_wr), 0);
    chk("abort_busy", 32'(cap_busy), 0);
    chk("abort_done", 32'(cap_done), 0);
    repeat (4) step();
    chk("abort_nwrites", wlog.size(), 1);
    wlog.delete();
    exp_s = '{16'h7788};
    start_cap(22'h000200, 16'd1);
    bus.sm_vld = 1;
    bus.sm_data = 16'h7788;
    step();
    bus.sm_vld = 0;
    wait_done(20);
    check_cap("restart", 22'h000200, 0);

    // contention: host on alternate cycles
    wlog.delete();
    exp_s.delete();
    nh = 0;
    start_cap(22'h000040, 16'd4);
    for (int i = 0; i < 40; i++) begin
      bus.fx_wr = (i % 2 == 0);
      bus.fx_waddr = 22'h200000 + 22'(i);
      bus.fx_data = 8'(i);
      if (bus.fx_wr) nh++;
      bus.sm_vld = (i < 16) && (i % 4 == 1);
      bus.sm_data = 16'hC000 + 16'(i);
      if (bus.sm_vld) exp_s.push_back(bus.sm_data);
      step();
    end
    bus.fx_wr = 0;
    bus.sm_vld = 0;
    wait_done(40);
    chk("cont_cnt", 32'(cap_cnt), 4);
    check_cap("cont", 22'h000040, 1);
    begin
      int hw;
      hw = 0;
      foreach (wlog[i]) if (wlog[i].a[21]) hw++;
      chk("cont_host_writes", hw, nh);
    end

    // overflow: FIFO fills while the host owns every cycle
    wlog.delete();
    exp_s.delete();
    start_cap(22'h001000, 16'd20);
    for (int i = 0; i < 20; i++) begin
      bus.fx_wr = 1;
      bus.fx_waddr = 22'h200000 + 22'(i);
      bus.fx_data = 8'(i);
      bus.sm_vld = 1;
      bus.sm_data = 16'h5000 + 16'(i);
      if (i < 8) exp_s.push_back(bus.sm_data);
      step();
    end
    bus.fx_wr = 0;
    bus.sm_vld = 0;
    repeat (30) step();
    chk("ovf_flag", 32'(cap_ovf), 1);
    chk("ovf_busy", 32'(cap_busy), 1);
    chk("ovf_done", 32'(cap_done), 0);
    chk("ovf_cnt", 32'(cap_cnt), 8);
    check_cap("ovf", 22'h001000, 1);
    cap_abort = 1;
    step();
    cap_abort = 0;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cap_start = ($urandom_range(0, 99) < 3);
      cap_abort = ($urandom_range(0, 999) < 4);
      cap_base = 22'($urandom);
      cap_len = 16'($urandom_range(0, 12));
      bus.fx_wr = ($urandom_range(0, 99) < 40);
      bus.fx_waddr = 22'($urandom);
      bus.fx_data = 8'($urandom);
      bus.sm_vld = ($urandom_range(0, 99) < 50);
      bus.sm_data = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
